// File: rtl/dds_param_ctrl.sv
// Front-panel control for the DDS/PWM core: debounced keys and switches adjust the
// frequency control word, and a two-digit decimal entry FSM commits the PWM duty or amplitude.
module dds_param_ctrl #(
    parameter int               FCW_W    = 32,
    parameter logic [FCW_W-1:0] FCW_DEF  = 'h1000,
    parameter logic [FCW_W-1:0] FCW_MIN  = 'h0010,
    parameter logic [FCW_W-1:0] FCW_MAX  = 'h0100_0000,
    parameter logic [FCW_W-1:0] STEP_DEF = 'h0100,
    parameter int               DEB_CYC  = 250
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       key,
    input  logic             sw12,
    input  logic             sw34,
    input  logic             sw_ok,
    input  logic             duty_sel,
    input  logic             sel_high,
    output logic [FCW_W-1:0] fcw,
    output logic [6:0]       duty,
    output logic [6:0]       amp,
    output logic             editing,
    output logic             param_upd
);
    localparam int               CW       = $clog2(DEB_CYC + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(DEB_CYC - 1);
    // Idle levels: keys active-high, switches active-low.
    localparam logic [9:0]       SYNC_RST = 10'b00_111_00000;
    localparam logic [7:0]       DEB_RST  = 8'b111_00000;
    localparam logic [FCW_W-1:0] STEP_MAX = {1'b1, {(FCW_W-1){1'b0}}};
    localparam logic [FCW_W-1:0] STEP_MIN = {{(FCW_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_EDIT, S_COMMIT} state_t;

    logic [9:0]       r_s1, r_s2;
    logic [CW-1:0]    r_cnt [8];
    logic [7:0]       r_deb, r_ev;
    logic             r_dsel_q;
    state_t           r_state, w_state_nxt;
    logic [3:0]       r_tens, r_ones, w_tens_nxt, w_ones_nxt;
    logic             w_commit;
    logic [FCW_W-1:0] r_fcw, r_step, w_fcw_nxt, w_step_nxt, w_step_app;
    logic [FCW_W+3:0] w_step_sh;
    logic [6:0]       r_duty, r_amp, w_tgt, w_val;
    logic             r_upd;
    logic             w_dsel, w_dsel_chg;

    function automatic logic [3:0] inc_digit(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    assign w_dsel     = r_s2[8];
    assign w_dsel_chg = (w_dsel != r_dsel_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1     <= SYNC_RST;
            r_s2     <= SYNC_RST;
            r_dsel_q <= 1'b0;
            r_deb    <= DEB_RST;
            r_ev     <= '0;
            for (int i = 0; i < 8; i++) r_cnt[i] <= '0;
        end else begin
            r_s1     <= {sel_high, duty_sel, sw_ok, sw34, sw12, key};
            r_s2     <= r_s1;
            r_dsel_q <= w_dsel;
            for (int i = 0; i < 8; i++) begin
                r_ev[i] <= 1'b0;
                if (r_s2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_cnt[i] <= '0;
                    r_deb[i] <= r_s2[i];
                    r_ev[i]  <= (r_s2[i] != DEB_RST[i]);
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Key actions: one per cycle in priority order, clamped with no wrap.
    always_comb begin
        w_step_sh  = {4'b0, r_step} << 4;
        w_step_app = r_step;
        if (r_s2[9])
            w_step_app = (w_step_sh > {4'b0, FCW_MAX}) ? FCW_MAX : w_step_sh[FCW_W-1:0];
        w_fcw_nxt  = r_fcw;
        w_step_nxt = r_step;
        if (r_ev[4]) begin
            w_fcw_nxt  = FCW_DEF;
            w_step_nxt = STEP_DEF;
        end else if (r_ev[0]) begin
            w_fcw_nxt = (w_step_app >= FCW_MAX - r_fcw) ? FCW_MAX : r_fcw + w_step_app;
        end else if (r_ev[1]) begin
            w_fcw_nxt = (w_step_app >= r_fcw - FCW_MIN) ? FCW_MIN : r_fcw - w_step_app;
        end else if (r_ev[2]) begin
            w_step_nxt = r_step[FCW_W-1] ? STEP_MAX : r_step << 1;
        end else if (r_ev[3]) begin
            w_step_nxt = (r_step == STEP_MIN) ? STEP_MIN : r_step >> 1;
        end
    end

    assign w_tgt = w_dsel ? r_amp : r_duty;
    assign w_val = 7'(r_tens) * 7'd10 + 7'(r_ones);

    always_comb begin
        w_state_nxt = r_state;
        w_tens_nxt  = r_tens;
        w_ones_nxt  = r_ones;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_ev[5] || r_ev[6]) begin
                    w_state_nxt = S_EDIT;
                    w_tens_nxt  = r_ev[5] ? inc_digit(4'(w_tgt / 7'd10)) : 4'(w_tgt / 7'd10);
                    w_ones_nxt  = r_ev[6] ? inc_digit(4'(w_tgt % 7'd10)) : 4'(w_tgt % 7'd10);
                end
            end
            S_EDIT: begin
                if (w_dsel_chg) begin
                    w_state_nxt = S_IDLE;
                end else if (r_ev[7]) begin
                    w_state_nxt = S_COMMIT;
                end else begin
                    if (r_ev[5]) w_tens_nxt = inc_digit(r_tens);
                    if (r_ev[6]) w_ones_nxt = inc_digit(r_ones);
                end
            end
            S_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (r_ev[4]) begin
            w_state_nxt = S_IDLE;
            w_commit    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_tens  <= '0;
            r_ones  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tens  <= w_tens_nxt;
            r_ones  <= w_ones_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fcw  <= FCW_DEF;
            r_step <= STEP_DEF;
            r_duty <= 7'd50;
            r_amp  <= 7'd99;
            r_upd  <= 1'b0;
        end else begin
            r_fcw  <= w_fcw_nxt;
            r_step <= w_step_nxt;
            r_upd  <= r_ev[4] || w_commit || (w_fcw_nxt != r_fcw);
            if (r_ev[4]) begin
                r_duty <= 7'd50;
                r_amp  <= 7'd99;
            end else if (w_commit) begin
                if (w_dsel) r_amp  <= w_val;
                else        r_duty <= (w_val == 7'd0) ? 7'd1 : w_val;
            end
        end
    end

    assign fcw       = r_fcw;
    assign duty      = r_duty;
    assign amp       = r_amp;
    assign editing   = (r_state == S_EDIT);
    assign param_upd = r_upd;
endmodule
